wb_cfg_master: RTL
==================

Name: wb_cfg_master

Overview:
- Wishbone classic single-cycle initiator that drives the PWM/timer core's slave port, so firmware-less sequencers and test logic can program Ctrl/Divisor/Period/DC registers.
- Accepts one command at a time on a valid/ready port and issues one Wishbone read or write.
- Returns read data and status on a valid/ready response port.
- Ends every stuck transfer with a bounded ACK timeout.

Parameters:
- AW, 16, Wishbone address width
- DW, 16, Wishbone data width
- TIMEOUT, 255, maximum WAIT-state cycles without ACK_I before abort; legal range 1..2^TO_W-1
- TO_W, 8, timeout counter width

Ports:
- CLK_I  in  1  system clock, all logic on rising edge
- RST_I  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  AW  target register address
- cmd_dat  in  DW  write data
- rsp_valid  out  1  response available, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_dat  out  DW  read data; 0 for plain writes and on error
- rsp_err  out  1  transfer aborted by timeout
- ADR_O  out  AW  Wishbone address
- DAT_O  out  DW  Wishbone write data
- DAT_I  in  DW  Wishbone read data
- WE_O  out  1  Wishbone write enable
- STB_O  out  1  Wishbone strobe
- CYC_O  out  1  Wishbone cycle; always equal to STB_O
- ACK_I  in  1  Wishbone acknowledge
- busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous: state=IDLE; STB_O, CYC_O, WE_O, rsp_valid and rsp_err all 0; ADR_O, DAT_O and rsp_dat all 0; timeout counter 0.
- All outputs are registered; cmd_ready and busy decode directly from the state register.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_we/adr/dat onto WE_O/ADR_O/DAT_O, set STB_O=CYC_O=1, go to REQ.
- REQ, one cycle:
  - ACK_I is ignored, because the slave's ACK is registered and the value sampled here is stale.
  - Go to WAIT with the counter cleared.
- WAIT:
  - ACK_I=1: drop STB_O/CYC_O/WE_O. On a read, latch DAT_I into rsp_dat; on a write, set rsp_dat=0. Set rsp_err=0, rsp_valid=1, go to RESP.
  - Otherwise, counter at TIMEOUT-1: drop STB/CYC/WE, rsp_dat=0, rsp_err=1, rsp_valid=1, go to RESP.
  - Otherwise, increment the counter.
- RESP:
  - The bus is idle, which guarantees at least one STB-low cycle between transfers.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - rsp_dat and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- Latency, zero-wait responder (ACK one cycle after STB): cmd handshake in cycle 0, STB high in cycles 1–2, rsp_valid high from cycle 3. Minimum command-to-command spacing is 4 cycles.
- ACK_I is ignored in IDLE, REQ and RESP, so ACK arriving outside WAIT has no effect.
- ACK_I and timeout in the same cycle: ACK wins, rsp_err=0.
- cmd_valid in any state other than IDLE is not accepted; the command must be held by the source.
- Reset mid-transfer: STB/CYC drop immediately; any pending response is discarded.

Optional Feature:
- Macro: WB_WRITE_VERIFY_EN.
- Defined: after a successful write ACK the master does not go to RESP. It passes through:
  - VGAP: one cycle, STB low.
  - VREQ: read of the same ADR_O, ACK ignored.
  - VWAIT: same ACK/timeout rules as WAIT.
- On VWAIT ACK: rsp_dat=DAT_I, rsp_mismatch=(DAT_I!=written data).
- A timeout in either phase sets rsp_err=1 and rsp_mismatch=0.
- Extra output port rsp_mismatch, 1 bit, reset 0.
- Zero-wait write latency becomes 7 cycles.
- Undefined: no verify states and no rsp_mismatch port.

Decomposition:
- Package pwm_wb_pkg holds:
  - AW/DW defaults.
  - State enum: IDLE, REQ, WAIT, VGAP, VREQ, VWAIT, RESP.
  - PWM core register address constants: CTRL=0x00, DIV=0x02, PER1=0x04, DC1=0x06, DC2=0x08, DC3=0x0A, DC4=0x0C, PER2=0x0E, PER3=0x10, PER4=0x12.
- One sub-module, wb_timeout_ctr: clear/enable inputs, expired output, parameterised by TIMEOUT/TO_W.

Test Plan:
- Write CTRL=0x0016 to a zero-wait responder: WE_O=1, ADR_O=0x0000, DAT_O=0x0016, STB_O/CYC_O high exactly cycles 1–2, rsp_valid at cycle 3, rsp_err=0, rsp_dat=0.
- Read DIV, responder gives 3 wait states then DAT_I=0x0004: STB held 5 cycles, rsp_dat=0x0004, rsp_err=0.
- No ACK with TIMEOUT=8: STB drops after 8 WAIT cycles, rsp_err=1, rsp_dat=0. A following command completes normally.
- rsp_ready held low 5 cycles: rsp_* stable, cmd_ready=0, STB_O=0 throughout. Back-to-back commands with rsp_ready=1 are spaced exactly 4 cycles.
- RST_I driven low while STB_O=1: STB_O, CYC_O and rsp_valid go 0 without a clock edge. After release, cmd_ready=1 and ACK pulses in IDLE are ignored.
- WB_WRITE_VERIFY_EN, write PER1=0x0100:
  - Responder returns 0x00FF on read-back: rsp_mismatch=1, rsp_dat=0x00FF.
  - Responder returns 0x0100: rsp_mismatch=0.
  - Write phase and read phase are separated by one STB-low cycle.

Source files
------------

// File: rtl/wb_cfg_master_pkg.sv
// Shared types and constants for the Wishbone configuration master that
// programs the PWM/timer core (Ctrl/Divisor/Period/DC registers).
package pwm_wb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        VGAP  = 3'd3,
        VREQ  = 3'd4,
        VWAIT = 3'd5,
        RESP  = 3'd6
    } wb_state_e;

    // PWM core register map
    localparam logic [15:0] ADR_CTRL = 16'h0000;
    localparam logic [15:0] ADR_DIV  = 16'h0002;
    localparam logic [15:0] ADR_PER1 = 16'h0004;
    localparam logic [15:0] ADR_DC1  = 16'h0006;
    localparam logic [15:0] ADR_DC2  = 16'h0008;
    localparam logic [15:0] ADR_DC3  = 16'h000A;
    localparam logic [15:0] ADR_DC4  = 16'h000C;
    localparam logic [15:0] ADR_PER2 = 16'h000E;
    localparam logic [15:0] ADR_PER3 = 16'h0010;
    localparam logic [15:0] ADR_PER4 = 16'h0012;

endpackage

// File: rtl/wb_cfg_master_if.sv
// Command, response and Wishbone signals of wb_cfg_master.
// WB_WRITE_VERIFY_EN adds the rsp_mismatch response bit.
interface wb_cfg_master_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
`ifdef WB_WRITE_VERIFY_EN
    logic          rsp_mismatch;
`endif

    logic [AW-1:0] ADR_O;
    logic [DW-1:0] DAT_O;
    logic [DW-1:0] DAT_I;
    logic          WE_O;
    logic          STB_O;
    logic          CYC_O;
    logic          ACK_I;
    logic          busy;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, DAT_I, ACK_I,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output ADR_O, DAT_O, WE_O, STB_O, CYC_O, busy
`ifdef WB_WRITE_VERIFY_EN
        , output rsp_mismatch
`endif
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, DAT_I, ACK_I,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  ADR_O, DAT_O, WE_O, STB_O, CYC_O, busy
`ifdef WB_WRITE_VERIFY_EN
        , input rsp_mismatch
`endif
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// ACK timeout counter: counts WAIT cycles, expired at TIMEOUT-1.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TO_W-1:0] cnt_q;

    // clear has priority so every bus phase starts from zero
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign expired = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_cfg_master.sv
// Wishbone classic single-cycle initiator for the PWM/timer core slave port.
// Optional macro WB_WRITE_VERIFY_EN: read back every acknowledged write and
// report rsp_mismatch.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// REQ   | first STB cycle, ACK_I is stale and ignored
// WAIT  | STB held until ACK_I or timeout
// VGAP  | one STB-low cycle between write and read-back
// VREQ  | first read-back STB cycle, ACK_I ignored
// VWAIT | read-back STB held until ACK_I or timeout
// RESP  | bus idle, response held until rsp_ready
module wb_cfg_master
    import pwm_wb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    wb_cfg_master_if.master bus
);
    wb_state_e     state_q, state_d;
    logic          we_q, we_d;
    logic          stb_q, stb_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;
    logic          to_clr, to_en, to_expired;
`ifdef WB_WRITE_VERIFY_EN
    logic          mis_q, mis_d;
`endif

    wb_timeout_ctr #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // state and all registered outputs
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef WB_WRITE_VERIFY_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            stb_q       <= stb_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
`ifdef WB_WRITE_VERIFY_EN
            mis_q       <= mis_d;
`endif
        end
    end

    // next state and next register values; ACK_I is only looked at in WAIT/VWAIT
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        stb_d       = stb_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        to_clr      = 1'b0;
        to_en       = 1'b0;
`ifdef WB_WRITE_VERIFY_EN
        mis_d       = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    we_d    = bus.cmd_we;
                    adr_d   = bus.cmd_adr;
                    dat_d   = bus.cmd_dat;
                    stb_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                to_clr  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.ACK_I) begin
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    rsp_err_d = 1'b0;
                    rsp_dat_d = we_q ? '0 : bus.DAT_I;
`ifdef WB_WRITE_VERIFY_EN
                    mis_d     = 1'b0;
                    if (we_q) begin
                        state_d = VGAP;
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
`else
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`endif
                end else if (to_expired) begin
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
`ifdef WB_WRITE_VERIFY_EN
                    mis_d       = 1'b0;
`endif
                    state_d     = RESP;
                end else begin
                    to_en = 1'b1;
                end
            end
`ifdef WB_WRITE_VERIFY_EN
            VGAP: begin
                stb_d   = 1'b1;
                state_d = VREQ;
            end
            VREQ: begin
                to_clr  = 1'b1;
                state_d = VWAIT;
            end
            VWAIT: begin
                if (bus.ACK_I) begin
                    stb_d       = 1'b0;
                    rsp_dat_d   = bus.DAT_I;
                    mis_d       = (bus.DAT_I != dat_q);
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (to_expired) begin
                    stb_d       = 1'b0;
                    rsp_dat_d   = '0;
                    mis_d       = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    to_en = 1'b1;
                end
            end
`endif
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                stb_d   = 1'b0;
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.ADR_O     = adr_q;
    assign bus.DAT_O     = dat_q;
    assign bus.WE_O      = we_q;
    assign bus.STB_O     = stb_q;
    assign bus.CYC_O     = stb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
`ifdef WB_WRITE_VERIFY_EN
    assign bus.rsp_mismatch = mis_q;
`endif

endmodule
